// File: rtl/div_disp_pkg.sv
// Shared definitions for the parametrised divider/display top: FSM state
// encoding, active-low seven-segment hex glyphs and a constant clog2 helper.
package div_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_hex_dec
  import div_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_cath
);

  assign o_cath = SEG_HEX[i_nib];

endmodule

// File: rtl/fsm_div_param_disp.sv
// Two-press operand capture, WIDTH-cycle restoring divider and a multiplexed
// hex display showing operands (A|B) or the result (Q|R).
module fsm_div_param_disp
  import div_disp_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 8,
  parameter int REFRESH_BITS = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_c_in,
  input  logic [WIDTH-1:0]  SW,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        CATH,
  output logic              valid_out_LED,
  output logic              dbz_LED
);

  localparam int IDX_W  = clog2(DIGITS);
  localparam int HALF_W = DIGITS * 2;
  localparam int CNT_W  = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t                  r_state;
  logic [WIDTH-1:0]        r_a, r_b, r_q, r_r;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_btn_q, r_valid, r_dbz;
  logic [REFRESH_BITS-1:0] r_scan;

  logic                    w_press;
  logic [WIDTH:0]          w_shr;
  logic                    w_ge;
  logic [HALF_W-1:0]       w_hi, w_lo;
  logic [2*HALF_W-1:0]     w_disp;
  logic [IDX_W-1:0]        w_idx;
  logic [3:0]              w_nib;

  assign w_press = btn_c_in & ~r_btn_q;

  // Partial remainder is one bit wider than B so the compare never overflows.
  assign w_shr = {r_r, r_q[WIDTH-1]};
  assign w_ge  = (w_shr >= {1'b0, r_b});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_btn_q <= 1'b0;
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
      r_scan  <= '0;
    end else begin
      r_btn_q <= btn_c_in;
      r_scan  <= r_scan + 1'b1;
      case (r_state)
        IDLE, DONE: begin
          if (w_press) begin
            r_a     <= SW;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_press) begin
            if (SW != '0) begin
              r_b     <= SW;
              r_r     <= '0;
              r_q     <= r_a;
              r_cnt   <= '0;
              r_state <= CALC;
            end else begin
              r_b     <= '0;
              r_q     <= '1;
              r_r     <= r_a;
              r_dbz   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        CALC: begin
          r_r   <= w_ge ? WIDTH'(w_shr - {1'b0, r_b}) : WIDTH'(w_shr);
          r_q   <= (r_q << 1) | WIDTH'(w_ge);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_hi = '0;
    w_lo = '0;
    if (r_state == DONE) begin
      w_hi[WIDTH-1:0] = r_q;
      w_lo[WIDTH-1:0] = r_r;
    end else begin
      w_hi[WIDTH-1:0] = r_a;
      w_lo[WIDTH-1:0] = r_b;
    end
  end

  assign w_disp = {w_hi, w_lo};
  assign w_idx  = r_scan[REFRESH_BITS-1 -: IDX_W];
  assign w_nib  = w_disp[{w_idx, 2'b00} +: 4];
  assign AN     = ~(DIGITS'(1) << w_idx);

  seg7_hex_dec u_dec (
    .i_nib  (w_nib),
    .o_cath (CATH)
  );

  assign valid_out_LED = r_valid;
  assign dbz_LED       = r_dbz;

endmodule

// File: tb/tb_fsm_div_param_disp.sv
// Scoreboard bench: three divider instances (WIDTH 8, 1, 16) driven by
// independent directed streams; monitors decode the scanned display.
module tb_fsm_div_param_disp;

  localparam int NI = 3;

  typedef struct {
    int          k;
    int          lat;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [NI];
  logic        btn [NI];
  logic [15:0] sw  [NI];
  logic [7:0]  an  [NI];
  logic [6:0]  cath[NI];
  logic        vld [NI];
  logic        dbz [NI];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sbq [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int g);
    return (g == 0) ? 8 : (g == 1) ? 1 : 16;
  endfunction

  function automatic logic [4:0] seg2hex(input logic [6:0] c);
    logic [6:0] tbl [0:15];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 16; i++)
      if (tbl[i] == c) return 5'(i);
    return 5'd16;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [W%0d] got %0h expected %0h at cycle %0d", nm, wid(g), act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W = (g == 0) ? 8 : (g == 1) ? 1 : 16;
    logic [4:0] scan_m;

    fsm_div_param_disp #(.WIDTH(W), .DIGITS(8), .REFRESH_BITS(5)) dut (
      .clk           (clk),
      .rst           (rst[g]),
      .btn_c_in      (btn[g]),
      .SW            (sw[g][W-1:0]),
      .AN            (an[g]),
      .CATH          (cath[g]),
      .valid_out_LED (vld[g]),
      .dbz_LED       (dbz[g])
    );

    always @(posedge clk) scan_m <= rst[g] ? 5'd0 : scan_m + 5'd1;

    initial begin : mon
      exp_t       e;
      logic       pv;
      logic [4:0] nib [8];
      int         an_bad, v_bad, s_bad;
      pv = 1'b0;
      forever begin
        @(negedge clk);
        if (vld[g] === 1'b1 && !pv) begin
          if (sbq[g].size() == 0) begin
            chk("unexpected_valid", g, 32'd1, 32'd0);
          end else begin
            e = sbq[g].pop_front();
            chk("latency", g, cyc - e.k, e.lat);
            chk("dbz", g, {31'd0, dbz[g]}, {31'd0, e.dbz});
            an_bad = 0; v_bad = 0; s_bad = 0;
            for (int i = 0; i < 8; i++) nib[i] = 5'd0;
            for (int i = 0; i < 32; i++) begin
              if (i > 0) @(negedge clk);
              if (an[g] !== ~(8'd1 << scan_m[4:2])) an_bad++;
              if (vld[g] !== 1'b1) v_bad++;
              nib[scan_m[4:2]] = seg2hex(cath[g]);
              if (nib[scan_m[4:2]] == 5'd16) s_bad++;
            end
            chk("scan_an", g, an_bad, 0);
            chk("valid_hold", g, v_bad, 0);
            chk("seg_pattern", g, s_bad, 0);
            chk("quot", g, {16'd0, nib[7][3:0], nib[6][3:0], nib[5][3:0], nib[4][3:0]}, {16'd0, e.q});
            chk("rem",  g, {16'd0, nib[3][3:0], nib[2][3:0], nib[1][3:0], nib[0][3:0]}, {16'd0, e.r});
          end
        end else if (sbq[g].size() > 0 && cyc > sbq[g][0].k + W + 4) begin
          chk("valid_timeout", g, 32'd0, 32'd1);
          void'(sbq[g].pop_front());
        end
        pv = vld[g];
      end
    end
  end

  task automatic drv_press(input int g, input logic [15:0] v);
    sw[g]  = v;
    btn[g] = 1'b1;
    @(negedge clk);
    btn[g] = 1'b0;
    @(negedge clk);
  endtask

  // Divisor press; the expected result is queued before the sampling edge.
  task automatic press_b(input int g, input logic [15:0] a_in, input logic [15:0] b_in, input bit push);
    exp_t        e;
    logic [15:0] m, a, b;
    m = 16'((32'd1 << wid(g)) - 1);
    a = a_in & m;
    b = b_in & m;
    sw[g]  = b_in;
    btn[g] = 1'b1;
    e.k = cyc + 1;
    if (b == 0) begin
      e.q = m; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = wid(g);
    end
    if (push) sbq[g].push_back(e);
    @(negedge clk);
    btn[g] = 1'b0;
  endtask

  task automatic settle(input int g);
    repeat (wid(g) + 36) @(negedge clk);
  endtask

  task automatic run(input int g, input logic [15:0] a, input logic [15:0] b);
    drv_press(g, a);
    press_b(g, a, b, 1'b1);
    settle(g);
  endtask

  task automatic rand_sweep(input int g, input int n);
    for (int i = 0; i < n; i++)
      run(g, 16'($urandom), (i == 2) ? 16'd0 : 16'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1; btn[g] = 1'b0; sw[g] = 16'd0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_valid", g, {31'd0, vld[g]}, 32'd0);
      chk("rst_dbz",   g, {31'd0, dbz[g]}, 32'd0);
      chk("rst_an",    g, {24'd0, an[g]}, 32'hFE);
      chk("rst_cath",  g, {25'd0, cath[g]}, 32'h40);
      rst[g] = 1'b0;
    end

    fork
      begin : s8
        // Held button: one capture only, even though SW changes mid-hold.
        sw[0] = 16'd200; btn[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (i == 5) sw[0] = 16'd7;
        end
        btn[0] = 1'b0;
        @(negedge clk);
        chk("hold_no_capture", 0, {31'd0, vld[0]}, 32'd0);
        press_b(0, 16'd200, 16'd7, 1'b1);
        settle(0);
        run(0, 16'd5, 16'd9);
        run(0, 16'd255, 16'd1);
        run(0, 16'd1, 16'd255);
        run(0, 16'd255, 16'd255);
        run(0, 16'd0, 16'd5);
        // Press during CALC must be dropped, not queued.
        drv_press(0, 16'd100);
        press_b(0, 16'd100, 16'd3, 1'b1);
        repeat (2) @(negedge clk);
        drv_press(0, 16'h55);
        settle(0);
        run(0, 16'd13, 16'd0);
        drv_press(0, 16'd77);
        chk("done_press_valid", 0, {31'd0, vld[0]}, 32'd0);
        chk("done_press_dbz",   0, {31'd0, dbz[0]}, 32'd0);
        press_b(0, 16'd77, 16'd7, 1'b1);
        settle(0);
        // Reset sampled on the third CALC edge.
        drv_press(0, 16'd50);
        press_b(0, 16'd50, 16'd3, 1'b0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("midcalc_rst_valid", 0, {31'd0, vld[0]}, 32'd0);
        chk("midcalc_rst_dbz",   0, {31'd0, dbz[0]}, 32'd0);
        chk("midcalc_rst_an",    0, {24'd0, an[0]}, 32'hFE);
        chk("midcalc_rst_cath",  0, {25'd0, cath[0]}, 32'h40);
        rst[0] = 1'b0;
        settle(0);
        run(0, 16'd100, 16'd10);
        rand_sweep(0, 4);
      end
      begin : s1
        run(1, 16'd0, 16'd1);
        run(1, 16'd1, 16'd1);
        run(1, 16'd1, 16'd0);
        run(1, 16'd0, 16'd0);
        rand_sweep(1, 4);
      end
      begin : s16
        run(2, 16'hFFFF, 16'd1);
        run(2, 16'd1, 16'hFFFF);
        run(2, 16'd40000, 16'd123);
        run(2, 16'hFFFF, 16'd0);
        run(2, 16'h8000, 16'd2);
        rand_sweep(2, 4);
      end
    join

    repeat (5) @(negedge clk);
    for (int g = 0; g < NI; g++) chk("sb_drained", g, sbq[g].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_div_param_disp.md
# fsm_div_param_disp

Parametrised successor to the fixed-width divider FSM top. It captures a dividend and then a divisor from the switch bus on successive button presses and runs a WIDTH-cycle restoring division. While idle or collecting operands it shows the operands on the multiplexed 7-segment display; once a result exists it shows quotient and remainder, and it flags division by zero. It sits directly under the VIO/board wrapper, replacing the fixed-width divider top.

## Interface
- WIDTH, 8: operand/result width; 1..16; ceil(WIDTH/4) <= DIGITS/2.
- DIGITS, 8: number of display digits; even power of two, 2..8.
- REFRESH_BITS, 17: width of the scan counter; must be greater than log2(DIGITS).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_c_in  in  1  load button, level input, rising edge is the action.
- SW  in  WIDTH  operand value.
- AN  out  DIGITS  digit enables, active low.
- CATH  out  7  segments {g,f,e,d,c,b,a}, active low.
- valid_out_LED  out  1  result valid.
- dbz_LED  out  1  last division had divisor 0.

## Operation
- Press detect:
  - btn_q is btn_c_in registered.
  - press = btn_c_in & ~btn_q.
  - A held-high button produces one press only.
- FSM states: IDLE, WAIT_B, CALC, DONE.
  - IDLE, press: A <= SW, B <= 0, valid <= 0, dbz <= 0; go to WAIT_B.
  - WAIT_B, press, SW != 0: B <= SW, R <= 0, Q <= A, cnt <= 0; go to CALC.
  - WAIT_B, press, SW == 0: B <= 0, Q <= all ones, R <= A, dbz <= 1; go to DONE.
  - CALC, each cycle, one restoring step on a (WIDTH+1)-bit partial remainder:
    - {R,Q} <= {R,Q} << 1.
    - If the shifted R >= B: R <= shifted R - B and Q[0] <= 1.
    - cnt increments.
    - Leave for DONE on the step where cnt == WIDTH-1.
  - DONE: valid = 1. Press behaves exactly as a press in IDLE, with new A captured.
  - Presses in CALC are ignored, and are not queued.
- Display value:
  - IDLE/WAIT_B: upper half shows A, lower half shows B.
  - CALC: shows A and B.
  - DONE: upper half shows Q, lower half shows R.
  - Each half is zero-extended hex, leading zeros shown, digit 0 is the least significant digit of the lower half.
- Scan:
  - Free-running REFRESH_BITS counter.
  - Digit index = top log2(DIGITS) bits of the counter.
  - AN = ~(1 << index).
  - CATH = hex pattern of the selected nibble (0 -> 7'b1000000, F -> 7'b0001110).

## Timing
- Reset values:
  - State IDLE; A, B, Q, R, cnt, btn_q, scan counter all 0.
  - valid_out_LED = 0, dbz_LED = 0.
  - AN = all ones except bit 0 = 0.
  - CATH = 7'b1000000.
- The press is sampled at edge k. Registers update at edge k.
- Normal divide: divisor press at edge k gives CALC from k. valid_out_LED is high after edge k+WIDTH, with Q and R final at the same time.
- Divide by zero: valid_out_LED and dbz_LED are high after edge k.
- rst in any state, including mid-CALC, aborts to the reset values at the next edge. No partial result is retained.
- AN and CATH are combinational from registered state and the scan counter; no additional latency.
- Each digit is active for 2^(REFRESH_BITS-log2(DIGITS)) cycles. The scan wraps from digit DIGITS-1 to digit 0 with no gap.

## Structure
- Shared package div_disp_pkg holds:
  - the state encoding constants (IDLE=0, WAIT_B=1, CALC=2, DONE=3);
  - the 16 hex segment patterns;
  - a clog2 function.
- One sub-module, seg7_hex_dec: 4-bit nibble in, 7-bit active-low CATH out, purely combinational.
- The FSM, datapath and scan counter are in the top module.

## Test plan
- Normal divide (WIDTH=8): press with SW=200, then press with SW=7.
  - Exactly 8 cycles later: valid=1, Q=0x1C, R=0x04, dbz=0.
- Divide by zero: press with SW=13, then press with SW=0.
  - Next cycle: valid=1, dbz=1, Q=0xFF, R=0x0D.
- Boundary cases:
  - 5/9 -> Q=0, R=5.
  - 255/1 -> Q=255, R=0.
  - 1/255 -> Q=0, R=1.
  - Random sweep checked against the reference model for WIDTH = 1, 8 and 16.
- Button handling:
  - btn_c_in held high for 20 cycles gives exactly one capture.
  - A press during CALC leaves A, B and the result unchanged.
  - A press in DONE starts a new operand A and drops valid to 0.
- Reset:
  - rst at cycle 3 of CALC: outputs return to the reset values next cycle.
  - A subsequent 100/10 divide gives Q=10, R=0.
- Scan (REFRESH_BITS=5, DIGITS=8), display of Q=0x1C, R=0x04:
  - AN cycles 0xFE, 0xFD, ... 0x7F with each held 4 cycles.
  - Digits read 4, 0, 0, 0, C, 1, 0, 0 in order.
  - CATH matches the package patterns.
